// File: rtl/iir_coeff_loader.sv
// Coefficient image loader for the time-multiplexed IIR SOS filter: streams, range-checks and
// checksums an image into a shadow bank, then commits it to the active bank on a frame boundary.
module iir_coeff_loader #(
  parameter int No_SOS       = 1,
  parameter int No_scale_Val = 5,
  parameter int WI_A         = 3,
  parameter int WF_A         = 8,
  parameter int WI_G         = 5,
  parameter int WF_G         = 11,
  parameter int W_BUS        = 16,
  localparam int CW   = WI_A + WF_A,
  localparam int GW   = WI_G + WF_G,
  localparam int NC   = 6 * No_SOS,
  localparam int CA_W = (NC > 1) ? $clog2(NC) : 1,
  localparam int SA_W = (No_scale_Val > 1) ? $clog2(No_scale_Val) : 1
) (
  input  logic             CLK,
  input  logic             nReset,
  input  logic             CE,
  input  logic             start,
  input  logic             s_valid,
  input  logic [W_BUS-1:0] s_data,
  output logic             s_ready,
  input  logic             swap_en,
  input  logic [CA_W-1:0]  coeff_addr,
  output logic [CW-1:0]    coeff_out,
  input  logic [SA_W-1:0]  scale_addr,
  output logic [GW-1:0]    scale_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int NMAX  = (NC > No_scale_Val) ? NC : No_scale_Val;
  localparam int CNT_W = $clog2(NMAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD_SCALE, LOAD_COEF, CHECK, WAIT_SWAP} state_t;
  state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic [W_BUS-1:0] acc;
  logic [GW-1:0]    sh_scale  [No_scale_Val];
  logic [GW-1:0]    act_scale [No_scale_Val];
  logic [CW-1:0]    sh_coef   [NC];
  logic [CW-1:0]    act_coef  [NC];

  logic xfer, commit, last_scale, last_coef, scale_ok, coef_ok, sum_bad;
  logic [W_BUS-GW:0] scale_hi;
  logic [W_BUS-CW:0] coef_hi;

  // Handshake: a word moves on an edge where CE, s_valid and s_ready are all high;
  // s_ready depends only on CE and state, never on s_valid. start on the same edge wins.
  assign s_ready    = CE && (state == LOAD_SCALE || state == LOAD_COEF || state == CHECK);
  assign xfer       = s_ready && s_valid && !start;
  assign commit     = CE && swap_en && !start && (state == WAIT_SWAP);
  assign last_scale = (cnt == CNT_W'(No_scale_Val - 1));
  assign last_coef  = (cnt == CNT_W'(NC - 1));
  assign scale_hi   = s_data[W_BUS-1:GW-1];
  assign coef_hi    = s_data[W_BUS-1:CW-1];
  assign scale_ok   = (&scale_hi) || !(|scale_hi);
  assign coef_ok    = (&coef_hi) || !(|coef_hi);
  assign sum_bad    = (s_data != acc);
  assign busy       = (state != IDLE);

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (CE && start) begin
      state_n = LOAD_SCALE;
    end else begin
      case (state)
        IDLE:       state_n = IDLE;
        LOAD_SCALE: if (xfer && last_scale) state_n = LOAD_COEF;
        LOAD_COEF:  if (xfer && last_coef) state_n = CHECK;
        CHECK:      if (xfer) state_n = (err_code[0] || sum_bad) ? IDLE : WAIT_SWAP;
        WAIT_SWAP:  if (commit) state_n = IDLE;
        default:    state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      cnt      <= '0;
      acc      <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
      done     <= 1'b0;
      for (int i = 0; i < No_scale_Val; i++) begin
        sh_scale[i]  <= '0;
        act_scale[i] <= '0;
      end
      for (int i = 0; i < NC; i++) begin
        sh_coef[i]  <= '0;
        act_coef[i] <= '0;
      end
    end else begin
      done <= commit;
      if (CE && start) begin
        cnt      <= '0;
        acc      <= '0;
        err      <= 1'b0;
        err_code <= 2'b00;
      end else if (xfer) begin
        case (state)
          LOAD_SCALE: begin
            for (int i = 0; i < No_scale_Val; i++)
              if (cnt == CNT_W'(i)) sh_scale[i] <= s_data[GW-1:0];
            acc <= acc + s_data;
            cnt <= last_scale ? '0 : cnt + 1'b1;
            if (!scale_ok) err_code[0] <= 1'b1;
          end
          LOAD_COEF: begin
            for (int i = 0; i < NC; i++)
              if (cnt == CNT_W'(i)) sh_coef[i] <= s_data[CW-1:0];
            acc <= acc + s_data;
            cnt <= last_coef ? '0 : cnt + 1'b1;
            if (!coef_ok) err_code[0] <= 1'b1;
          end
          CHECK: begin
            err <= err_code[0] || sum_bad;
            if (sum_bad) err_code[1] <= 1'b1;
          end
          default: ;
        endcase
      end
      // Both banks switch on the same edge so the filter never reads a mixed set.
      if (commit) begin
        for (int i = 0; i < No_scale_Val; i++) act_scale[i] <= sh_scale[i];
        for (int i = 0; i < NC; i++) act_coef[i] <= sh_coef[i];
      end
    end
  end

  assign coeff_out = ({1'b0, coeff_addr} < (CA_W+1)'(NC)) ? act_coef[coeff_addr] : '0;
  assign scale_out = ({1'b0, scale_addr} < (SA_W+1)'(No_scale_Val)) ? act_scale[scale_addr] : '0;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader: good image, range error, checksum error, CE gating,
// mid-load restart and start/swap collision, with hand-computed banks.
module tb_iir_coeff_loader;

  logic        CLK = 1'b0;
  logic        nReset = 1'b0;
  logic        CE = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic        swap_en = 1'b0;
  logic [2:0]  coeff_addr = '0;
  logic [10:0] coeff_out;
  logic [2:0]  scale_addr = '0;
  logic [15:0] scale_out;
  logic        busy, done, err;
  logic [1:0]  err_code;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  bit ce_ph = 1'b0;

  iir_coeff_loader dut (
    .CLK(CLK), .nReset(nReset), .CE(CE), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .swap_en(swap_en),
    .coeff_addr(coeff_addr), .coeff_out(coeff_out),
    .scale_addr(scale_addr), .scale_out(scale_out),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (done) done_cnt++;

  // Image A: Q5.11 scale 1.0 x5, coefficients, checksum = 0x2800 + 0x04C0.
  logic [15:0] img_a [12] = '{16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800,
                              16'h0100, 16'h0200, 16'h0100, 16'h0100, 16'hFF80, 16'h0040,
                              16'h2CC0};
  // Image B: checksum = 0x1400 + 0x015F.
  logic [15:0] img_b [12] = '{16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400,
                              16'h0010, 16'h0020, 16'h0030, 16'h0100, 16'hFC00, 16'h03FF,
                              16'h155F};
  logic [15:0] img [12];
  logic [10:0] exp_coef [6];
  logic [15:0] exp_scale [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_exp_zero();
    for (int i = 0; i < 6; i++) exp_coef[i] = '0;
    for (int i = 0; i < 5; i++) exp_scale[i] = '0;
  endtask

  task automatic set_exp_a();
    exp_coef = '{11'h100, 11'h200, 11'h100, 11'h100, 11'h780, 11'h040};
    for (int i = 0; i < 5; i++) exp_scale[i] = 16'h0800;
  endtask

  task automatic set_exp_b();
    exp_coef = '{11'h010, 11'h020, 11'h030, 11'h100, 11'h400, 11'h3FF};
    for (int i = 0; i < 5; i++) exp_scale[i] = 16'h0400;
  endtask

  // Sweeps every address including out-of-range ones, then resyncs to posedge+1.
  task automatic check_bank(input string tag);
    for (int a = 0; a < 8; a++) begin
      coeff_addr = 3'(a);
      scale_addr = 3'(a);
      #1;
      check({tag, "_coef"}, coeff_out, (a < 6) ? exp_coef[a] : 11'h0);
      check({tag, "_scale"}, scale_out, (a < 5) ? exp_scale[a] : 16'h0);
    end
    step();
  endtask

  task automatic do_start();
    CE = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit jitter);
    bit took = 1'b0;
    int n = 0;
    s_data = w;
    while (!took && n < 100) begin
      if (jitter) begin
        CE = ce_ph;
        ce_ph = ~ce_ph;
        s_valid = 1'($urandom_range(0, 1));
      end else begin
        CE = 1'b1;
        s_valid = 1'b1;
      end
      #1;
      if (!CE) check("ready_ce0", s_ready, 1'b0);
      took = CE && s_valid && s_ready;
      @(posedge CLK);
      #1;
      n++;
    end
    s_valid = 1'b0;
    CE = 1'b1;
    check("xfer_timeout", took, 1'b1);
  endtask

  task automatic send_image(input int nwords, input bit jitter);
    for (int i = 0; i < nwords; i++) send_word(img[i], jitter);
  endtask

  task automatic do_swap();
    CE = 1'b1;
    swap_en = 1'b1;
    step();
    swap_en = 1'b0;
  endtask

  initial begin
    int d0;
    // 1: reset state, then asynchronous reset in the middle of a load
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_ready", s_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", {err, err_code}, 3'b000);
    repeat (2) @(posedge CLK);
    #1;
    nReset = 1'b1;
    img = img_a;
    do_start();
    send_image(3, 1'b0);
    #2;
    nReset = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_ready", s_ready, 1'b0);
    check("arst_err", {err, err_code}, 3'b000);
    @(posedge CLK);
    #1;
    nReset = 1'b1;
    set_exp_zero();
    check_bank("rst_bank");
    check("rst_busy2", busy, 1'b0);

    // 2: good image A, CE=0 masks swap_en, single done
    d0 = done_cnt;
    do_start();
    check("t2_busy", busy, 1'b1);
    send_image(12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t2_wait_busy", busy, 1'b1);
      check("t2_wait_done", done, 1'b0);
      step();
    end
    check_bank("t2_old");
    CE = 1'b0;
    swap_en = 1'b1;
    step();
    swap_en = 1'b0;
    CE = 1'b1;
    check("t2_ce0_done", done, 1'b0);
    check("t2_ce0_busy", busy, 1'b1);
    do_swap();
    check("t2_done", done, 1'b1);
    check("t2_busy_end", busy, 1'b0);
    step();
    check("t2_done_pulse", done, 1'b0);
    check("t2_err", {err, err_code}, 3'b000);
    set_exp_a();
    check_bank("t2_new");
    check("t2_done_cnt", done_cnt - d0, 1);

    // 3: range violation on a coefficient word with a correct checksum
    d0 = done_cnt;
    img = img_a;
    img[6] = 16'h0400;
    img[11] = 16'h2EC0;
    do_start();
    send_image(12, 1'b0);
    check("t3_err", err, 1'b1);
    check("t3_code", err_code, 2'b01);
    check("t3_busy", busy, 1'b0);
    do_swap();
    step();
    check("t3_no_done", done_cnt - d0, 0);
    check_bank("t3_bank");

    // 4: checksum mismatch, then start clears the error
    img = img_a;
    img[11] = 16'h2CC1;
    do_start();
    send_image(12, 1'b0);
    check("t4_err", err, 1'b1);
    check("t4_code", err_code, 2'b10);
    check("t4_busy", busy, 1'b0);
    do_start();
    check("t4_clr_err", err, 1'b0);
    check("t4_clr_code", err_code, 2'b00);
    check("t4_busy2", busy, 1'b1);

    // 5: CE gated every other cycle, random s_valid, image B (restarts the pending load)
    d0 = done_cnt;
    img = img_b;
    do_start();
    send_image(12, 1'b1);
    step();
    step();
    check("t5_wait_busy", busy, 1'b1);
    do_swap();
    check("t5_done", done, 1'b1);
    step();
    set_exp_b();
    check_bank("t5_bank");
    check("t5_done_cnt", done_cnt - d0, 1);

    // 6a: restart after word 7, then a full image A
    d0 = done_cnt;
    img = img_a;
    do_start();
    send_image(7, 1'b0);
    do_start();
    send_image(12, 1'b0);
    check("t6a_busy", busy, 1'b1);
    do_swap();
    step();
    check("t6a_err", {err, err_code}, 3'b000);
    set_exp_a();
    check_bank("t6a_bank");
    check("t6a_done_cnt", done_cnt - d0, 1);

    // 6b: start and swap_en together in WAIT_SWAP
    d0 = done_cnt;
    img = img_b;
    do_start();
    send_image(12, 1'b0);
    check("t6b_wait", busy, 1'b1);
    start = 1'b1;
    swap_en = 1'b1;
    step();
    start = 1'b0;
    swap_en = 1'b0;
    check("t6b_no_done", done, 1'b0);
    check("t6b_busy", busy, 1'b1);
    check("t6b_ready", s_ready, 1'b1);
    check_bank("t6b_old");
    send_image(12, 1'b0);
    do_swap();
    step();
    set_exp_b();
    check_bank("t6b_new");
    check("t6b_done_cnt", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
